// File: rtl/dma_priority_arbiter.sv
// DMA request/priority front end: conditions DREQ with polarity, mask and
// software requests, runs the HRQ/HLDA hold handshake, and latches one
// channel (fixed or rotating priority) as a registered grant for the
// timing-and-control state machine. DACK is held until transferDone.
module dma_priority_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              dreqActiveLow,
    input  logic              rotatingPriority,
    input  logic              controllerDisable,
    input  logic [NUM_CH-1:0] mask,
    input  logic [NUM_CH-1:0] swReq,
    input  logic              transferDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantChannel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t            state_reg;
    logic              hrq_reg;
    logic [NUM_CH-1:0] dack_reg;
    logic              grant_valid_reg;
    logic [CH_W-1:0]   grant_channel_reg;
    logic [CH_W-1:0]   rot_ptr_reg;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [CH_W-1:0]   winner_next;
    logic [NUM_CH-1:0] winner_onehot;
    logic [CH_W-1:0]   rot_ptr_next;

    // Effective per-channel request and one-hot decode of the winner
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign req[gi]           = ((DREQ[gi] ^ dreqActiveLow) & ~mask[gi]) | swReq[gi];
        assign winner_onehot[gi] = (winner_next == CH_W'(gi));
    end

    assign any_req = |req;

    // Pointer value after completing service on the latched channel
    assign rot_ptr_next = CH_W'((int'(grant_channel_reg) + 1) % NUM_CH);

    // Priority search starting at rot_ptr; lowest offset from the pointer wins
    always_comb begin
        int idx;
        idx         = 0;
        winner_next = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            idx = (int'(rot_ptr_reg) + off) % NUM_CH;
            if (req[idx]) begin
                winner_next = CH_W'(idx);
            end
        end
    end

    // Hold-handshake FSM with registered outputs and rotation pointer
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg         <= IDLE;
            hrq_reg           <= 1'b0;
            dack_reg          <= '0;
            grant_valid_reg   <= 1'b0;
            grant_channel_reg <= '0;
            rot_ptr_reg       <= '0;
        end else begin
            // Fixed mode pins the highest priority to channel 0
            if (!rotatingPriority) begin
                rot_ptr_reg <= '0;
            end

            case (state_reg)
                IDLE: begin
                    hrq_reg <= 1'b0;
                    if (any_req && !controllerDisable) begin
                        state_reg <= REQ;
                        hrq_reg   <= 1'b1;
                    end
                end

                REQ: begin
                    if (HLDA && any_req) begin
                        state_reg         <= GRANT;
                        dack_reg          <= winner_onehot;
                        grant_valid_reg   <= 1'b1;
                        grant_channel_reg <= winner_next;
                    end else if (!HLDA && !any_req) begin
                        state_reg <= IDLE;
                        hrq_reg   <= 1'b0;
                    end
                end

                GRANT: begin
                    // Completion wins over a simultaneous HLDA drop
                    if (transferDone || !HLDA) begin
                        state_reg       <= IDLE;
                        hrq_reg         <= 1'b0;
                        dack_reg        <= '0;
                        grant_valid_reg <= 1'b0;
                        if (transferDone && rotatingPriority) begin
                            rot_ptr_reg <= rot_ptr_next;
                        end
                    end
                end

                default: begin
                    state_reg       <= IDLE;
                    hrq_reg         <= 1'b0;
                    dack_reg        <= '0;
                    grant_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign HRQ          = hrq_reg;
    assign DACK         = dack_reg;
    assign grantValid   = grant_valid_reg;
    assign grantChannel = grant_channel_reg;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter: stimulus pushes the expected
// granted channel, a monitor pops and compares on every new grant.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       HLDA;
    logic       dreqActiveLow;
    logic       rotatingPriority;
    logic       controllerDisable;
    logic [3:0] mask;
    logic [3:0] swReq;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    dma_priority_arbiter #(.NUM_CH(4)) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .DREQ             (DREQ),
        .HLDA             (HLDA),
        .dreqActiveLow    (dreqActiveLow),
        .rotatingPriority (rotatingPriority),
        .controllerDisable(controllerDisable),
        .mask             (mask),
        .swReq            (swReq),
        .transferDone     (transferDone),
        .HRQ              (HRQ),
        .DACK             (DACK),
        .grantValid       (grantValid),
        .grantChannel     (grantChannel)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Request already applied with state IDLE and HLDA low: raise HLDA after HRQ
    task automatic do_grant(input int ch);
        tick();
        check("hrq_before_grant", 32'(HRQ), 32'd1);
        HLDA = 1'b1;
        exp_q.push_back(ch);
        tick();
        check("grant_valid_up", 32'(grantValid), 32'd1);
    endtask

    // Completion together with HLDA falling still counts as completion
    task automatic complete();
        transferDone = 1'b1;
        HLDA         = 1'b0;
        tick();
        transferDone = 1'b0;
        check("done_clears_grant", {HRQ, grantValid, DACK}, 32'd0);
    endtask

    // Monitor: compare every new grant against the scoreboard, plus invariants
    logic prev_gv = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (grantValid && !prev_gv) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL grant_unexpected: got ch=%0d dack=%b expected no grant", grantChannel, DACK);
            end else begin
                int ch;
                logic [3:0] exp_dack;
                ch       = exp_q.pop_front();
                exp_dack = 4'b0001 << ch;
                if (grantChannel !== 2'(ch) || DACK !== exp_dack) begin
                    bad++;
                    $display("FAIL grant_match: got ch=%0d dack=%b expected ch=%0d dack=%b",
                             grantChannel, DACK, ch, exp_dack);
                end else begin
                    $display("ok   grant_match: ch=%0d dack=%b", grantChannel, DACK);
                end
            end
        end
        if ((grantValid !== (|DACK)) || ($countones(DACK) > 1)) begin
            total++;
            bad++;
            $display("FAIL dack_invariant: got gv=%b dack=%b expected gv==|dack and one-hot", grantValid, DACK);
        end
        prev_gv = grantValid;
    end

    initial begin
        RESET_N = 1'b0; DREQ = '0; HLDA = 1'b0; dreqActiveLow = 1'b0;
        rotatingPriority = 1'b0; controllerDisable = 1'b0; mask = '0;
        swReq = '0; transferDone = 1'b0;
        tick(); tick();
        check("reset_outputs", {HRQ, grantValid, DACK, grantChannel}, 32'd0);
        RESET_N = 1'b1;
        tick();
        check("idle_after_reset", 32'(HRQ), 32'd0);

        // Fixed priority: ch1 beats ch2, grant held against input changes
        DREQ = 4'b0110;
        tick();
        check("fixed_hrq_rise", 32'(HRQ), 32'd1);
        tick();
        HLDA = 1'b1;
        exp_q.push_back(1);
        tick();
        check("fixed_dack", 32'(DACK), 32'h2);
        DREQ = 4'b1111; mask = 4'b0010; rotatingPriority = 1'b1;
        tick();
        rotatingPriority = 1'b0;
        check("grant_latched", {DACK, grantChannel}, {4'b0010, 2'd1});
        DREQ = '0; mask = '0;
        complete();
        check("channel_holds", 32'(grantChannel), 32'd1);
        tick();
        check("stays_idle", 32'(HRQ), 32'd0);

        // Controller disable blocks IDLE->REQ
        controllerDisable = 1'b1; DREQ = 4'b0001;
        tick(); tick();
        check("disable_blocks", 32'(HRQ), 32'd0);
        DREQ = '0; controllerDisable = 1'b0;
        tick();

        // Rotating priority: all channels requesting, order 0,1,2,3,0
        rotatingPriority = 1'b1; DREQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            do_grant(k % 4);
            complete();
        end
        DREQ = '0;
        rotatingPriority = 1'b0;
        tick(); tick();

        // Mask and polarity
        mask = 4'b0001; DREQ = 4'b0001;
        tick(); tick(); tick();
        check("masked_no_hrq", 32'(HRQ), 32'd0);
        dreqActiveLow = 1'b1; mask = 4'b1110; DREQ = 4'b1110;
        do_grant(0);
        DREQ = 4'b1111;
        complete();
        mask = 4'b0100; swReq = 4'b0100;
        do_grant(2);
        swReq = '0;
        complete();
        dreqActiveLow = 1'b0; DREQ = '0; mask = '0;
        tick();

        // Request withdrawal without HLDA
        DREQ = 4'b1000;
        tick();
        check("withdraw_hrq_up", 32'(HRQ), 32'd1);
        tick();
        DREQ = '0;
        tick();
        check("withdraw_hrq_down", {HRQ, DACK}, 32'd0);
        tick();

        // HLDA abort mid-grant leaves the rotation pointer alone
        rotatingPriority = 1'b1; DREQ = 4'b0100;
        do_grant(2);
        HLDA = 1'b0; DREQ = '0;
        tick();
        check("abort_clears", {HRQ, grantValid, DACK}, 32'd0);
        DREQ = 4'b0101;
        do_grant(0);
        DREQ = '0;
        complete();
        tick();

        // Async reset in GRANT (pointer is now 1; ch0 only requester)
        DREQ = 4'b0001;
        do_grant(0);
        #3;
        RESET_N = 1'b0;
        #1;
        check("async_reset", {HRQ, grantValid, DACK}, 32'd0);
        DREQ = '0; HLDA = 1'b0;
        RESET_N = 1'b1;
        tick(); tick();
        check("idle_after_async", {HRQ, grantValid}, 32'd0);

        // Pointer cleared by reset: ch0 wins with all requesting in rotating mode
        DREQ = 4'b1111;
        do_grant(0);
        DREQ = '0;
        complete();
        tick(); tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
